// File: rtl/fir_data_write_fsm_pkg.sv
// Shared definitions for the FIR tap-history producer and the pipe sequencer:
// write FSM state encoding and the circular-pointer wrap increment.
package fir_data_write_fsm_pkg;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_WRITE = 3'd1,
    S_END   = 3'd2,
    S_ARM   = 3'd3,
    S_WAIT  = 3'd4
  } state_t;

  // Advance a history pointer by one, wrapping at depth (which need not be a
  // power of two). Callers truncate the result to their pointer width.
  function automatic logic [31:0] wrap_inc(input logic [31:0] ptr,
                                           input logic [31:0] depth);
    return (ptr == depth - 32'd1) ? 32'd0 : ptr + 32'd1;
  endfunction

endpackage

// File: rtl/fir_data_write_fsm.sv
// Producer side of the FIR tap-history memory. Writes one frame of per-channel
// samples into the circular history at {channel, wr_ptr}, pulses
// end_write_data when the frame is complete, and drops (and flags) samples
// that arrive while the FIR pass is still running.
module fir_data_write_fsm
  import fir_data_write_fsm_pkg::*;
#(
  parameter int CHANNELS        = 8,
  parameter int CHANNELS_WIDTH  = 3,
  parameter int FIR_TAP         = 128,
  parameter int TAP_COUNT_WIDTH = $clog2(FIR_TAP),
  parameter int DATA_WIDTH      = 16
) (
  input  logic                                  clk,
  input  logic                                  resetn,
  input  logic                                  in_valid,
  input  logic                                  in_first,
  input  logic [DATA_WIDTH-1:0]                 in_data,
  input  logic                                  fir_busy,
  input  logic                                  overrun_clr,
  output logic                                  mem_we,
  output logic [CHANNELS_WIDTH+TAP_COUNT_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0]                 mem_wdata,
  output logic                                  end_write_data,
  output logic [TAP_COUNT_WIDTH-1:0]            newest_ptr,
  output logic                                  overrun,
  output logic                                  frame_err
);

  localparam logic [CHANNELS_WIDTH-1:0] CH_ZERO = '0;
  localparam logic [CHANNELS_WIDTH-1:0] CH_ONE  = CHANNELS_WIDTH'(1);
  localparam logic [CHANNELS_WIDTH-1:0] CH_LAST = CHANNELS_WIDTH'(CHANNELS - 1);

  state_t                                  state, state_n;
  logic [CHANNELS_WIDTH-1:0]               channel_cnt, channel_cnt_n;
  logic [TAP_COUNT_WIDTH-1:0]              wr_ptr, wr_ptr_n;
  logic                                    mem_we_n;
  logic [CHANNELS_WIDTH+TAP_COUNT_WIDTH-1:0] mem_addr_n;
  logic [DATA_WIDTH-1:0]                   mem_wdata_n;
  logic                                    end_write_data_n;
  logic [TAP_COUNT_WIDTH-1:0]              newest_ptr_n;
  logic                                    overrun_n, frame_err_n;
  logic                                    overrun_set, frame_err_set;

  // Next-state, next-pointer and next-output decode for the write FSM.
  always_comb begin
    // NOTE: every signal assigned here gets a default first, so no path can
    // leave it unassigned and infer a latch.
    state_n          = state;
    channel_cnt_n    = channel_cnt;
    wr_ptr_n         = wr_ptr;
    mem_we_n         = 1'b0;
    mem_addr_n       = mem_addr;
    mem_wdata_n      = mem_wdata;
    end_write_data_n = 1'b0;
    newest_ptr_n     = newest_ptr;
    overrun_set      = 1'b0;
    frame_err_set    = 1'b0;

    case (state)
      S_IDLE: begin
        // Samples without in_first are discarded while waiting for alignment.
        if (in_valid && in_first) begin
          mem_we_n      = 1'b1;
          mem_addr_n    = {CH_ZERO, wr_ptr};
          mem_wdata_n   = in_data;
          channel_cnt_n = CH_ONE;
          state_n       = (CHANNELS == 1) ? S_END : S_WRITE;
        end
      end

      S_WRITE: begin
        if (in_valid) begin
          mem_we_n    = 1'b1;
          mem_wdata_n = in_data;
          if (in_first) begin
            // Resync: abandon the partial frame and restart at channel 0
            // in the same history slot.
            frame_err_set = 1'b1;
            mem_addr_n    = {CH_ZERO, wr_ptr};
            channel_cnt_n = CH_ONE;
            state_n       = (CHANNELS == 1) ? S_END : S_WRITE;
          end else begin
            mem_addr_n    = {channel_cnt, wr_ptr};
            channel_cnt_n = channel_cnt + CH_ONE;
            if (channel_cnt == CH_LAST) state_n = S_END;
          end
        end
      end

      S_END: begin
        end_write_data_n = 1'b1;
        newest_ptr_n     = wr_ptr;
        wr_ptr_n         = TAP_COUNT_WIDTH'(wrap_inc(32'(wr_ptr), 32'(FIR_TAP)));
        channel_cnt_n    = CH_ZERO;
        overrun_set      = in_valid;
        state_n          = S_ARM;
      end

      S_ARM: begin
        // One cycle for the sequencer to raise fir_busy.
        overrun_set = in_valid;
        state_n     = S_WAIT;
      end

      S_WAIT: begin
        overrun_set = in_valid;
        if (!fir_busy) state_n = S_IDLE;
      end

      default: state_n = S_IDLE;
    endcase

    // A set in the same cycle wins over the clear.
    overrun_n   = overrun_set   ? 1'b1 : (overrun_clr ? 1'b0 : overrun);
    frame_err_n = frame_err_set ? 1'b1 : (overrun_clr ? 1'b0 : frame_err);
  end

  // State, counters and all outputs registered; resetn is active-high async.
  always_ff @(posedge clk or posedge resetn) begin
    if (resetn) begin
      state          <= S_IDLE;
      channel_cnt    <= '0;
      wr_ptr         <= '0;
      mem_we         <= 1'b0;
      mem_addr       <= '0;
      mem_wdata      <= '0;
      end_write_data <= 1'b0;
      newest_ptr     <= '0;
      overrun        <= 1'b0;
      frame_err      <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the values
      // computed from the previous cycle, independent of statement order.
      state          <= state_n;
      channel_cnt    <= channel_cnt_n;
      wr_ptr         <= wr_ptr_n;
      mem_we         <= mem_we_n;
      mem_addr       <= mem_addr_n;
      mem_wdata      <= mem_wdata_n;
      end_write_data <= end_write_data_n;
      newest_ptr     <= newest_ptr_n;
      overrun        <= overrun_n;
      frame_err      <= frame_err_n;
    end
  end

endmodule

// File: tb/tb_fir_data_write_fsm.sv
// Directed self-checking bench for fir_data_write_fsm (4 channels, 5-deep
// history). Expected writes and end pulses go into scoreboard queues when
// stimulus is driven; monitors pop and compare when the DUT produces them.
module tb_fir_data_write_fsm;

  localparam int CHANNELS        = 4;
  localparam int CHANNELS_WIDTH  = 2;
  localparam int FIR_TAP         = 5;
  localparam int TAP_COUNT_WIDTH = 3;
  localparam int DATA_WIDTH      = 16;
  localparam int ADDR_WIDTH      = CHANNELS_WIDTH + TAP_COUNT_WIDTH;

  typedef struct {
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] data;
    int                    due;
  } wr_t;

  typedef struct {
    logic [TAP_COUNT_WIDTH-1:0] ptr;
    int                         due;
  } end_t;

  logic                       clk = 1'b0;
  logic                       resetn;
  logic                       in_valid, in_first, fir_busy, overrun_clr;
  logic [DATA_WIDTH-1:0]      in_data;
  logic                       mem_we, end_write_data, overrun, frame_err;
  logic [ADDR_WIDTH-1:0]      mem_addr;
  logic [DATA_WIDTH-1:0]      mem_wdata;
  logic [TAP_COUNT_WIDTH-1:0] newest_ptr;

  int   errors    = 0;
  int   checks    = 0;
  int   cyc       = 0;
  int   end_count = 0;
  logic [TAP_COUNT_WIDTH-1:0] exp_ptr = '0;
  wr_t  wr_q[$];
  end_t end_q[$];

  fir_data_write_fsm #(
    .CHANNELS        (CHANNELS),
    .CHANNELS_WIDTH  (CHANNELS_WIDTH),
    .FIR_TAP         (FIR_TAP),
    .TAP_COUNT_WIDTH (TAP_COUNT_WIDTH),
    .DATA_WIDTH      (DATA_WIDTH)
  ) dut (
    .clk            (clk),
    .resetn         (resetn),
    .in_valid       (in_valid),
    .in_first       (in_first),
    .in_data        (in_data),
    .fir_busy       (fir_busy),
    .overrun_clr    (overrun_clr),
    .mem_we         (mem_we),
    .mem_addr       (mem_addr),
    .mem_wdata      (mem_wdata),
    .end_write_data (end_write_data),
    .newest_ptr     (newest_ptr),
    .overrun        (overrun),
    .frame_err      (frame_err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Write monitor: every mem_we must match the oldest expected write.
  always @(negedge clk) begin
    wr_t w;
    if (mem_we === 1'b1) begin
      check("write_was_expected", 32'(wr_q.size() != 0), 32'd1);
      if (wr_q.size() != 0) begin
        w = wr_q.pop_front();
        check("wr_addr", 32'(mem_addr), 32'(w.addr));
        check("wr_data", 32'(mem_wdata), 32'(w.data));
        check("wr_cycle", 32'(cyc), 32'(w.due));
      end
    end
  end

  // End-pulse monitor: every pulse must match the oldest expected frame end.
  always @(negedge clk) begin
    end_t e;
    if (end_write_data === 1'b1) begin
      end_count++;
      check("end_was_expected", 32'(end_q.size() != 0), 32'd1);
      if (end_q.size() != 0) begin
        e = end_q.pop_front();
        check("newest_ptr", 32'(newest_ptr), 32'(e.ptr));
        check("end_cycle", 32'(cyc), 32'(e.due));
      end
    end
  end

  task automatic send(input logic first, input logic [DATA_WIDTH-1:0] data,
                      input logic expect_wr, input logic [CHANNELS_WIDTH-1:0] ch,
                      input logic [TAP_COUNT_WIDTH-1:0] ptr);
    wr_t w;
    @(posedge clk); #1;
    in_valid = 1'b1;
    in_first = first;
    in_data  = data;
    if (expect_wr) begin
      w.addr = {ch, ptr};
      w.data = data;
      w.due  = cyc + 1;
      wr_q.push_back(w);
    end
  endtask

  // Called in the same cycle the last sample of a frame is driven.
  task automatic expect_end(input logic [TAP_COUNT_WIDTH-1:0] ptr);
    end_t e;
    e.ptr = ptr;
    e.due = cyc + 2;
    end_q.push_back(e);
  endtask

  task automatic advance_ptr();
    exp_ptr = (exp_ptr == 3'(FIR_TAP - 1)) ? 3'd0 : exp_ptr + 3'd1;
  endtask

  task automatic idle(input int n);
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_first = 1'b0;
    repeat (n - 1) @(posedge clk);
  endtask

  task automatic frame_samples(input logic [DATA_WIDTH-1:0] base);
    for (int ch = 0; ch < CHANNELS; ch++)
      send(ch == 0, 16'(base + 16'(ch) * 16'h11), 1'b1, 2'(ch), exp_ptr);
    expect_end(exp_ptr);
    advance_ptr();
  endtask

  task automatic send_frame(input logic [DATA_WIDTH-1:0] base, input int busy_cycles);
    frame_samples(base);
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_first = 1'b0;
    fir_busy = (busy_cycles != 0);
    repeat (busy_cycles) @(posedge clk);
    #1 fir_busy = 1'b0;
    repeat (4) @(posedge clk);
  endtask

  task automatic pulse_clr();
    @(posedge clk); #1 overrun_clr = 1'b1;
    @(posedge clk); #1 overrun_clr = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_mem_we"}, 32'(mem_we), 32'd0);
    check({tag, "_mem_addr"}, 32'(mem_addr), 32'd0);
    check({tag, "_mem_wdata"}, 32'(mem_wdata), 32'd0);
    check({tag, "_end"}, 32'(end_write_data), 32'd0);
    check({tag, "_newest_ptr"}, 32'(newest_ptr), 32'd0);
    check({tag, "_overrun"}, 32'(overrun), 32'd0);
    check({tag, "_frame_err"}, 32'(frame_err), 32'd0);
  endtask

  initial begin
    resetn = 1'b1; in_valid = 1'b0; in_first = 1'b0; in_data = '0;
    fir_busy = 1'b0; overrun_clr = 1'b0;

    // Reset state.
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_all_zero("reset");
    @(posedge clk); #1 resetn = 1'b0;

    // Unaligned samples from reset: no writes, no flags.
    send(1'b0, 16'hA1, 1'b0, 2'd0, 3'd0);
    send(1'b0, 16'hA2, 1'b0, 2'd0, 3'd0);
    send(1'b0, 16'hA3, 1'b0, 2'd0, 3'd0);
    idle(3);
    @(negedge clk);
    check("align_overrun", 32'(overrun), 32'd0);
    check("align_frame_err", 32'(frame_err), 32'd0);
    check("align_no_end", 32'(end_count), 32'd0);

    // First frame 0x11..0x44 into slot 0, sequencer idle.
    send_frame(16'h11, 0);
    check("frame1_end_count", 32'(end_count), 32'd1);

    // Five more frames with fir_busy held: newest_ptr 1,2,3,4 then wrap to 0.
    for (int f = 1; f < 6; f++) send_frame(16'(16'h100 * f), 10);
    check("six_frames_end_count", 32'(end_count), 32'd6);

    // Overrun: drop while busy, clear, then drop and clear together.
    frame_samples(16'h600);
    @(posedge clk); #1;
    in_valid = 1'b0; in_first = 1'b0; fir_busy = 1'b1;
    repeat (2) @(posedge clk);
    #1 in_valid = 1'b1; in_data = 16'h99;
    @(posedge clk); #1 in_valid = 1'b0;
    @(negedge clk);
    check("overrun_set", 32'(overrun), 32'd1);
    pulse_clr();
    @(negedge clk);
    check("overrun_cleared", 32'(overrun), 32'd0);
    @(posedge clk); #1 in_valid = 1'b1; overrun_clr = 1'b1;
    @(posedge clk); #1 in_valid = 1'b0; overrun_clr = 1'b0;
    @(negedge clk);
    check("overrun_set_beats_clr", 32'(overrun), 32'd1);
    pulse_clr();
    @(negedge clk);
    check("overrun_cleared_again", 32'(overrun), 32'd0);
    @(posedge clk); #1 fir_busy = 1'b0;
    repeat (4) @(posedge clk);
    check("overrun_frame_end_count", 32'(end_count), 32'd7);

    // Resync: in_first arrives on channel 2's slot.
    send(1'b1, 16'hC0, 1'b1, 2'd0, exp_ptr);
    send(1'b0, 16'hC1, 1'b1, 2'd1, exp_ptr);
    send(1'b1, 16'hC2, 1'b1, 2'd0, exp_ptr);
    idle(1);
    @(negedge clk);
    check("resync_frame_err", 32'(frame_err), 32'd1);
    check("resync_no_end", 32'(end_count), 32'd7);
    send(1'b0, 16'hC3, 1'b1, 2'd1, exp_ptr);
    send(1'b0, 16'hC4, 1'b1, 2'd2, exp_ptr);
    send(1'b0, 16'hC5, 1'b1, 2'd3, exp_ptr);
    expect_end(exp_ptr);
    advance_ptr();
    idle(6);
    check("resync_end_count", 32'(end_count), 32'd8);
    pulse_clr();
    @(negedge clk);
    check("frame_err_cleared", 32'(frame_err), 32'd0);
    // Pointer advanced exactly once across the resynced frame.
    send_frame(16'h500, 0);
    check("post_resync_end_count", 32'(end_count), 32'd9);

    // Reset in the middle of a frame.
    send(1'b1, 16'hD0, 1'b1, 2'd0, exp_ptr);
    send(1'b0, 16'hD1, 1'b1, 2'd1, exp_ptr);
    idle(2);
    @(posedge clk); #1 resetn = 1'b1;
    @(negedge clk);
    check_all_zero("midreset");
    repeat (2) @(posedge clk);
    #1 resetn = 1'b0;
    exp_ptr = '0;
    idle(3);
    check("midreset_no_end", 32'(end_count), 32'd9);
    send_frame(16'h700, 0);
    check("post_reset_end_count", 32'(end_count), 32'd10);

    check("writes_outstanding", 32'(wr_q.size()), 32'd0);
    check("ends_outstanding", 32'(end_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
